// File: rtl/load_read_unit.sv
// Load controller: issues a word-aligned memory read, then extracts and extends
// the addressed byte/halfword/word. Flags misalignment, illegal funct3 and timeouts.
module load_read_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  output logic        mem_rd_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rd_ack,
  input  logic [31:0] mem_rd_data,
  output logic [31:0] data_out,
  output logic        done,
  output logic        busy,
  output logic        misaligned_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q;
  logic [31:0]      addr_q;
  logic [2:0]       f3_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      data_q;
  logic             req_q;
  logic             done_q;
  logic             mis_q;
  logic             bus_q;

  logic [31:0]      data_d;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic             req_bad;

  // Request legality is judged on the live inputs so the error path skips REQ.
  always_comb begin
    req_bad = 1'b0;
    case (funct3)
      3'b000, 3'b100: req_bad = 1'b0;
      3'b001, 3'b101: req_bad = addr[0];
      3'b010:         req_bad = (addr[1:0] != 2'b00);
      default:        req_bad = 1'b1;
    endcase
  end

  always_comb begin
    byte_sel = '0;
    case (addr_q[1:0])
      2'd0: byte_sel = mem_rd_data[7:0];
      2'd1: byte_sel = mem_rd_data[15:8];
      2'd2: byte_sel = mem_rd_data[23:16];
      2'd3: byte_sel = mem_rd_data[31:24];
      default: byte_sel = '0;
    endcase
    half_sel = addr_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    data_d = '0;
    case (f3_q)
      3'b000:  data_d = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  data_d = {{16{half_sel[15]}}, half_sel};
      3'b010:  data_d = mem_rd_data;
      3'b100:  data_d = {24'd0, byte_sel};
      3'b101:  data_d = {16'd0, half_sel};
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      bus_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q <= addr;
            f3_q   <= funct3;
            cnt_q  <= '0;
            data_q <= '0;
            bus_q  <= 1'b0;
            if (req_bad) begin
              mis_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              mis_q   <= 1'b0;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end
          end
        end
        S_REQ: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_rd_ack) begin
            data_q  <= data_d;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            data_q  <= '0;
            bus_q   <= 1'b1;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd_req     = req_q;
  assign mem_addr       = {addr_q[31:2], 2'b00};
  assign data_out       = data_q;
  assign done           = done_q;
  assign busy           = (state_q != S_IDLE);
  assign misaligned_err = mis_q;
  assign bus_err        = bus_q;

endmodule

// File: tb/tb_load_read_unit.sv
// Bench for load_read_unit: directed scenarios plus randomized loads checked
// against an arithmetic reference of the load rules.
module tb_load_read_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] addr = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic        mem_rd_ack = 1'b0;
  logic [31:0] mem_rd_data = '0;
  logic [31:0] data_out;
  logic        done;
  logic        busy;
  logic        misaligned_err;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_read_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .funct3(funct3),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_ack(mem_rd_ack),
    .mem_rd_data(mem_rd_data), .data_out(data_out), .done(done), .busy(busy),
    .misaligned_err(misaligned_err), .bus_err(bus_err)
  );

  function automatic logic ref_bad(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0, 3'd4: return 1'b0;
      3'd1, 3'd5: return (a % 2) != 0;
      3'd2:       return (a % 4) != 0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    int unsigned off = a % 4;
    logic [31:0] b = (w >> (8 * off)) & 32'hFF;
    logic [31:0] h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: return 32'd0;
    endcase
  endfunction

  // Drives one load and plays memory; ack is given on REQ cycle index ack_at.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w,
                         input int ack_at, input logic idle_ack,
                         output logic [31:0] dout, output logic mis, output logic berr,
                         output int lat, output int reqc, output logic [31:0] maddr,
                         output logic addr_bad);
    @(negedge clk);
    start = 1'b1; addr = a; funct3 = f3; mem_rd_ack = idle_ack; mem_rd_data = $urandom;
    lat = 999; reqc = 0; maddr = '0; addr_bad = 1'b0; dout = '0; mis = 1'b0; berr = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      start = 1'b0; mem_rd_ack = 1'b0; mem_rd_data = $urandom;
      if (mem_rd_req) begin
        if (reqc == 0) maddr = mem_addr;
        else if (mem_addr !== maddr) addr_bad = 1'b1;
        if (reqc == ack_at) begin
          mem_rd_ack = 1'b1; mem_rd_data = w;
        end
        reqc++;
      end
      if (done) begin
        lat = cyc; dout = data_out; mis = misaligned_err; berr = bus_err;
        if (mem_rd_req) addr_bad = 1'b1;
        break;
      end
    end
    mem_rd_ack = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, ma; logic m, b, ab; int l, r;
    logic [68:0] outs;
    @(negedge clk); @(negedge clk);
    outs = {mem_rd_req, mem_addr, data_out, done, busy, misaligned_err, bus_err};
    checks++;
    if (outs !== 69'd0) begin
      errors++; $display("FAIL reset_state: got %h expected 0", outs);
    end
    rst = 1'b1;
    do_load(3'b010, 32'h40, 32'hCAFEF00D, 0, 1'b0, d, m, b, l, r, ma, ab);
    checks++;
    if (d !== 32'hCAFEF00D) begin
      errors++; $display("FAIL pre_abort_lw: got %h expected cafef00d", d);
    end
    @(negedge clk);
    start = 1'b1; addr = 32'h80; funct3 = 3'b010;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_rd_req !== 1'b1) begin
      errors++; $display("FAIL abort_in_req: mem_rd_req got %b expected 1", mem_rd_req);
    end
    rst = 1'b0;
    #1;
    outs = {mem_rd_req, mem_addr, data_out, done, busy, misaligned_err, bus_err};
    checks++;
    if (outs !== 69'd0) begin
      errors++; $display("FAIL reset_abort_outputs: got %h expected 0", outs);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL reset_no_done: done/busy got %b%b expected 00", done, busy);
      end
    end
  endtask

  task automatic test_lw();
    logic [31:0] d, ma; logic m, b, ab; int l, r;
    do_load(3'b010, 32'h100, 32'hDEADBEEF, 0, 1'b0, d, m, b, l, r, ma, ab);
    checks++;
    if (ma !== 32'h100 || ab) begin
      errors++; $display("FAIL lw_mem_addr: got %h (unstable=%b) expected 00000100", ma, ab);
    end
    checks++;
    if (l != 2) begin
      errors++; $display("FAIL lw_latency: got %0d expected 2", l);
    end
    checks++;
    if (d !== 32'hDEADBEEF || m !== 1'b0 || b !== 1'b0) begin
      errors++; $display("FAIL lw_data: got %h mis=%b bus=%b expected deadbeef 0 0", d, m, b);
    end
  endtask

  task automatic test_byte();
    logic [31:0] d, ma; logic m, b, ab; int l, r;
    logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b000};
    logic [31:0] as  [3] = '{32'h103, 32'h103, 32'h101};
    logic [31:0] exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'h00000012};
    for (int i = 0; i < 3; i++) begin
      do_load(f3s[i], as[i], 32'h80FF1234, 0, 1'b0, d, m, b, l, r, ma, ab);
      checks++;
      if (d !== exp[i] || ma !== 32'h100) begin
        errors++; $display("FAIL byte_load[%0d]: got %h addr %h expected %h addr 00000100",
                           i, d, ma, exp[i]);
      end
    end
  endtask

  task automatic test_half();
    logic [31:0] d, ma; logic m, b, ab; int l, r;
    do_load(3'b001, 32'h202, 32'h9ABC0001, 0, 1'b0, d, m, b, l, r, ma, ab);
    checks++;
    if (d !== 32'hFFFF9ABC) begin
      errors++; $display("FAIL lh: got %h expected ffff9abc", d);
    end
    do_load(3'b101, 32'h202, 32'h9ABC0001, 0, 1'b0, d, m, b, l, r, ma, ab);
    checks++;
    if (d !== 32'h00009ABC) begin
      errors++; $display("FAIL lhu: got %h expected 00009abc", d);
    end
    do_load(3'b001, 32'h201, 32'h9ABC0001, 0, 1'b0, d, m, b, l, r, ma, ab);
    checks++;
    if (m !== 1'b1 || l != 1 || r != 0 || d !== 32'd0) begin
      errors++; $display("FAIL lh_misaligned: mis=%b lat=%0d reqs=%0d data=%h expected 1 1 0 0",
                         m, l, r, d);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] d, ma; logic m, b, ab; int l, r;
    logic [2:0] ill [3] = '{3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 3; i++) begin
      do_load(ill[i], 32'h500, 32'h12345678, 0, 1'b0, d, m, b, l, r, ma, ab);
      checks++;
      if (m !== 1'b1 || b !== 1'b0 || d !== 32'd0 || r != 0 || l != 1) begin
        errors++; $display("FAIL illegal_f3[%0d]: mis=%b bus=%b data=%h reqs=%0d lat=%0d expected 1 0 0 0 1",
                           i, m, b, d, r, l);
      end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] d, ma; logic m, b, ab; int l, r;
    do_load(3'b010, 32'h400, 32'h55AA55AA, 99, 1'b0, d, m, b, l, r, ma, ab);
    checks++;
    if (r != TO || b !== 1'b1 || d !== 32'd0 || l != TO + 1) begin
      errors++; $display("FAIL timeout: reqs=%0d bus=%b data=%h lat=%0d expected %0d 1 0 %0d",
                         r, b, d, l, TO, TO + 1);
    end
    do_load(3'b010, 32'h400, 32'h55AA55AA, TO - 1, 1'b0, d, m, b, l, r, ma, ab);
    checks++;
    if (r != TO || b !== 1'b0 || d !== 32'h55AA55AA) begin
      errors++; $display("FAIL timeout_ack_wins: reqs=%0d bus=%b data=%h expected %0d 0 55aa55aa",
                         r, b, d, TO);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs;
    logic [3:0] exp [4] = '{4'b1010, 4'b0110, 4'b0000, 4'b1010};
    @(negedge clk);
    start = 1'b1; addr = 32'h300; funct3 = 3'b010;
    mem_rd_ack = 1'b1; mem_rd_data = 32'h11112222;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_rd_data = 32'h33334444;
      @(negedge clk);
      obs = {mem_rd_req, done, busy, 1'b0};
      checks++;
      if (obs !== exp[i]) begin
        errors++; $display("FAIL b2b_cycle%0d: req,done,busy got %b expected %b",
                           i + 1, obs[3:1], exp[i][3:1]);
      end
      if (i == 1) begin
        checks++;
        if (data_out !== 32'h11112222) begin
          errors++; $display("FAIL b2b_first_data: got %h expected 11112222", data_out);
        end
      end
    end
    start = 1'b0;
    @(negedge clk);
    mem_rd_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || data_out !== 32'h33334444) begin
      errors++; $display("FAIL b2b_second: done=%b data=%h expected 1 33334444", done, data_out);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, ma, a, w, exp_d; logic m, b, ab, exp_m, exp_b; int l, r, k, exp_l, exp_r;
    logic [2:0] f3;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      w  = $urandom;
      k  = int'($urandom_range(0, TO + 1));
      do_load(f3, a, w, k, 1'($urandom_range(0, 1)), d, m, b, l, r, ma, ab);
      exp_m = ref_bad(f3, a);
      if (exp_m) begin
        exp_b = 1'b0; exp_d = '0; exp_r = 0; exp_l = 1;
      end else if (k < TO) begin
        exp_b = 1'b0; exp_d = ref_load(f3, a, w); exp_r = k + 1; exp_l = k + 2;
      end else begin
        exp_b = 1'b1; exp_d = '0; exp_r = TO; exp_l = TO + 1;
      end
      checks++;
      if (d !== exp_d || m !== exp_m || b !== exp_b || l != exp_l || r != exp_r ||
          ab || (r > 0 && ma !== (a & 32'hFFFFFFFC))) begin
        errors++;
        $display("FAIL random[%0d] f3=%0d addr=%h word=%h ack_at=%0d: got data=%h mis=%b bus=%b lat=%0d reqs=%0d maddr=%h unstable=%b expected data=%h mis=%b bus=%b lat=%0d reqs=%0d",
                 i, f3, a, w, k, d, m, b, l, r, ma, ab, exp_d, exp_m, exp_b, exp_l, exp_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte();
    test_half();
    test_illegal();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
